mem_sequencer: RTL and testbench
================================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for mem_ready per access before a bus error.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port pc, input, 32: fetch address from the datapath PC.
REQ-005 SHALL have port instr, output, 32: latched instruction word to the datapath.
REQ-006 SHALL have port dm_req, input, 1: current instruction needs a data access (load or store).
REQ-007 SHALL have port dm_we, input, 1: data access is a store.
REQ-008 SHALL have port dm_addr, input, 32: data address (datapath ALU result).
REQ-009 SHALL have port dm_wdata, input, 32: store data.
REQ-010 SHALL have port dm_rdata, output, 32: latched load data to the datapath ReadData.
REQ-011 SHALL have port stall, output, 1: holds PC and register-file writes while 1.
REQ-012 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32) and mem_wdata (output, 32): shared single-port memory request.
REQ-013 SHALL have ports mem_rdata (input, 32) and mem_ready (input, 1): memory response, valid in the cycle mem_ready=1.
REQ-014 SHALL have port bus_err, output, 1: sticky timeout flag.
REQ-015 SHALL have port instret, output, 32: retired-instruction counter.

Function
REQ-016 SHALL implement an FSM with states FETCH, EXEC, WB and HALT.
REQ-017 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc and stall=1; on mem_ready it SHALL latch mem_rdata into instr and go to EXEC.
REQ-018 EXEC with dm_req=0 SHALL drive stall=0 and mem_req=0 for exactly one cycle (commit), then go to FETCH.
REQ-019 EXEC with dm_req=1 SHALL drive mem_req=1, mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata and stall=1; on mem_ready it SHALL latch mem_rdata into dm_rdata (loads only) and go to WB.
REQ-020 WB SHALL drive stall=0 and mem_req=0 for exactly one cycle (commit), then go to FETCH.
REQ-021 A memory request SHALL be held stable (addr, we, wdata) from assertion until the mem_ready cycle inclusive.
REQ-022 mem_ready SHALL be ignored when mem_req=0.
REQ-023 A wait counter SHALL clear on each new request and increment on each cycle a request is pending without mem_ready.
REQ-024 When the wait counter reaches TIMEOUT without mem_ready, the block SHALL set bus_err=1 and go to HALT.
REQ-025 mem_ready in the same cycle the counter reaches TIMEOUT SHALL complete normally, with no error.
REQ-026 HALT SHALL hold stall=1 and mem_req=0 and SHALL leave only on reset.
REQ-027 instret SHALL increment by 1 on every commit cycle (stall=0) and wrap from 0xFFFFFFFF to 0.
REQ-028 Minimum latency SHALL be 2 cycles per non-memory instruction (FETCH, EXEC) and 3 cycles per load/store (FETCH, EXEC, WB) with zero-wait memory.
REQ-029 instr and dm_rdata SHALL change only on their latch events.

Reset
REQ-030 On reset the block SHALL enter FETCH and clear instr, dm_rdata, instret, the wait counter and bus_err to 0.
REQ-031 While reset is asserted, outputs SHALL be stall=1, mem_req=0 and mem_we=0.
REQ-032 Reset asserted mid-access SHALL abandon the access immediately; a late mem_ready SHALL be ignored.
REQ-033 After reset release, the first mem_req SHALL be a fetch at the current pc.

Verification
REQ-034 pc=0x0, zero-wait memory returns 0x00500093, dm_req=0 -> instr=0x00500093 after 1 cycle, stall=0 for one cycle, instret=1.
REQ-035 Load, dm_addr=0x100, memory returns 0xDEADBEEF after 3 wait cycles -> mem_addr=0x100 held stable for 4 cycles, dm_rdata=0xDEADBEEF, stall=0 in WB only.
REQ-036 Store, dm_addr=0x104, dm_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 until mem_ready; dm_rdata unchanged.
REQ-037 mem_ready never asserted, TIMEOUT=15 -> bus_err=1 after 15 pending cycles, HALT with stall=1 thereafter; mem_ready on exactly cycle 15 -> no error.
REQ-038 Reset pulsed during a pending fetch -> stall=1, mem_req=0 during reset; all outputs cleared; the next fetch uses the new pc.
REQ-039 instret preloaded near wrap (0xFFFFFFFF) by running, then one more commit -> instret=0.

Source files
------------

// File: rtl/mem_sequencer.sv
// Fetch/execute sequencer that shares one single-port memory between instruction
// fetch and load/store, with a per-access wait timeout that latches a sticky bus error.
module mem_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err,
    output logic [31:0] instret
);

    // FETCH: instruction read | EXEC: commit or data access | WB: data commit | HALT: bus error
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic [WW-1:0] wait_q;
    logic [31:0]   instr_q;
    logic [31:0]   dm_rdata_q;
    logic          bus_err_q;
    logic [31:0]   instret_q;

    logic          fetch_act;
    logic          data_act;
    logic          commit;
    logic          wait_tc;
    logic [WW-1:0] wait_d;
    logic [31:0]   instret_d;

    assign fetch_act = (state_q == S_FETCH);
    assign data_act  = (state_q == S_EXEC) && dm_req;
    assign commit    = !reset && (((state_q == S_EXEC) && !dm_req) || (state_q == S_WB));
    assign wait_tc   = (wait_q == WW'(TIMEOUT));
    assign wait_d    = wait_q + WW'(1);
    assign instret_d = instret_q + 32'd1;

    // Request strobes are gated by reset so an in-flight access drops the moment reset asserts.
    assign mem_req   = !reset && (fetch_act || data_act);
    assign mem_we    = !reset && data_act && dm_we;
    assign mem_addr  = data_act ? dm_addr : (fetch_act ? pc : 32'd0);
    assign mem_wdata = data_act ? dm_wdata : 32'd0;
    assign stall     = !commit;

    assign instr     = instr_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;
    assign instret   = instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_q     <= '0;
            instr_q    <= 32'd0;
            dm_rdata_q <= 32'd0;
            bus_err_q  <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            if (commit) begin
                instret_q <= instret_d;
            end
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        instr_q <= mem_rdata;
                        wait_q  <= '0;
                        state_q <= S_EXEC;
                    end else if (wait_tc) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_EXEC: begin
                    if (!dm_req) begin
                        state_q <= S_FETCH;
                    end else if (mem_ready) begin
                        if (!dm_we) begin
                            dm_rdata_q <= mem_rdata;
                        end
                        wait_q  <= '0;
                        state_q <= S_WB;
                    end else if (wait_tc) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed and randomized bench for mem_sequencer; a per-instruction reference model
// predicts every cycle of the bus handshake, the latched words and the retire count.
module tb_mem_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_instret;

    mem_sequencer #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_instr   = 32'd0;
        exp_rdata   = 32'd0;
        exp_instret = 32'd0;
    endtask

    // One whole instruction: fetch answered after fw idle cycles, optional data access
    // answered after dw idle cycles. Starts and ends just after a falling edge.
    task automatic run_instr(input logic [31:0] a_pc, input logic [31:0] iw,
                             input logic dreq, input logic dwe,
                             input logic [31:0] daddr, input logic [31:0] dwd,
                             input logic [31:0] drd, input int fw, input int dw);
        pc       = a_pc;
        dm_req   = dreq;
        dm_we    = dwe;
        dm_addr  = daddr;
        dm_wdata = dwd;
        for (int k = 0; k <= fw; k++) begin
            mem_ready = (k == fw);
            mem_rdata = (k == fw) ? iw : $urandom();
            #1;
            chk("fetch_req",   {31'd0, mem_req}, 32'd1);
            chk("fetch_we",    {31'd0, mem_we},  32'd0);
            chk("fetch_addr",  mem_addr, a_pc);
            chk("fetch_stall", {31'd0, stall},   32'd1);
            chk("instr_hold",  instr, exp_instr);
            chk("instret",     instret, exp_instret);
            chk("no_bus_err",  {31'd0, bus_err}, 32'd0);
            @(negedge clk);
        end
        exp_instr = iw;
        if (!dreq) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            #1;
            chk("exec_stall",   {31'd0, stall},   32'd0);
            chk("exec_req",     {31'd0, mem_req}, 32'd0);
            chk("exec_instr",   instr, exp_instr);
            chk("exec_instret", instret, exp_instret);
            @(negedge clk);
            exp_instret = exp_instret + 32'd1;
        end else begin
            for (int k = 0; k <= dw; k++) begin
                mem_ready = (k == dw);
                mem_rdata = (k == dw) ? drd : $urandom();
                #1;
                chk("data_req",   {31'd0, mem_req}, 32'd1);
                chk("data_we",    {31'd0, mem_we},  {31'd0, dwe});
                chk("data_addr",  mem_addr, daddr);
                chk("data_wdata", mem_wdata, dwd);
                chk("data_stall", {31'd0, stall},   32'd1);
                chk("rdata_hold", dm_rdata, exp_rdata);
                chk("data_instr", instr, exp_instr);
                @(negedge clk);
            end
            if (!dwe) exp_rdata = drd;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            #1;
            chk("wb_stall",   {31'd0, stall},   32'd0);
            chk("wb_req",     {31'd0, mem_req}, 32'd0);
            chk("wb_rdata",   dm_rdata, exp_rdata);
            chk("wb_instret", instret, exp_instret);
            @(negedge clk);
            exp_instret = exp_instret + 32'd1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"},   {31'd0, stall},   32'd1);
        chk({tag, "_req"},     {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"},      {31'd0, mem_we},  32'd0);
        chk({tag, "_instr"},   instr,    32'd0);
        chk({tag, "_rdata"},   dm_rdata, 32'd0);
        chk({tag, "_instret"}, instret,  32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        logic        r_dreq;
        logic        r_dwe;
        int          r_fw;
        int          r_dw;

        reset     = 1'b1;
        pc        = 32'd0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        mem_rdata = 32'd0;
        mem_ready = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Zero-wait ALU instruction at pc 0
        run_instr(32'h0, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
        // Load with three wait cycles, then store
        run_instr(32'h4, 32'h1000_2003, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 3);
        run_instr(32'h8, 32'h1230_0023, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 32'h5555_AAAA, 1, 2);
        // Waits exactly at the timeout limit still complete without error
        run_instr(32'hC, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, TO, 0);
        run_instr(32'h10, 32'hCAFE_0002, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0BAD_F00D, 2, TO);

        for (int i = 0; i < 40; i++) begin
            r_dreq = 1'($urandom_range(0, 1));
            r_dwe  = 1'($urandom_range(0, 1));
            r_fw   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 2));
            r_dw   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 2));
            run_instr($urandom() & 32'hFFFF_FFFC, $urandom(), r_dreq, r_dwe,
                      $urandom(), $urandom(), $urandom(), r_fw, r_dw);
        end

        // Retire counter wrap: preload just below the wrap point
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFE;
        run_instr(32'h40, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
        run_instr(32'h44, 32'h0000_0013, 1'b1, 1'b0, 32'h80, 32'h0, 32'h7777_0000, 0, 0);
        #1;
        chk("instret_wrap", instret, 32'd0);
        @(negedge clk);
        chk("instret_wrap_hold", instret, 32'd0);

        // Reset in the middle of a pending fetch; a ready during reset is ignored.
        // The partial fetch above consumed one wait cycle, so instret is still 0.
        pc = 32'h200;
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("pend_req", {31'd0, mem_req}, 32'd1);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk_reset_outputs("late_rdy");
        mem_ready = 1'b0;
        pc = 32'h300;
        reset = 1'b0;
        model_reset();
        run_instr(32'h300, 32'h0AA0_0113, 1'b1, 1'b0, 32'h180, 32'h0, 32'h1357_9BDF, 1, 1);

        // Fetch never answered: TO idle cycles plus the final allowed cycle, then HALT
        pc = 32'h400;
        for (int k = 0; k <= TO; k++) begin
            mem_ready = 1'b0;
            #1;
            chk("to_req",     {31'd0, mem_req}, 32'd1);
            chk("to_no_err",  {31'd0, bus_err}, 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            dm_req    = 1'($urandom_range(0, 1));
            #1;
            chk("halt_err",     {31'd0, bus_err}, 32'd1);
            chk("halt_stall",   {31'd0, stall},   32'd1);
            chk("halt_req",     {31'd0, mem_req}, 32'd0);
            chk("halt_instret", instret, exp_instret);
            chk("halt_instr",   instr, exp_instr);
            @(negedge clk);
        end
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk_reset_outputs("halt_rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_instr(32'h500, 32'h0FF0_0093, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
        #1;
        chk("final_instret", instret, exp_instret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
